// File: rtl/rf_ctr_pkg.sv
// Shared types and constants for the receive-board SPI bus schedulers.
package rf_ctr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] GNT_POLL = 2'd0;
  localparam logic [1:0] GNT_RD   = 2'd1;
  localparam logic [1:0] GNT_WR   = 2'd2;

  localparam int POLL_DIV_DEF = 20;
  localparam int TIMEOUT_DEF  = 1023;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for a slow level from another clock domain plus a
// rising-edge pulse taken from the synchronized level.
module sync_edge_det (
  input  logic sys_clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/spi2_access_sched.sv
// Arbitrates the second SPI bus (AD7884 readback) between a periodic power
// poll, host reads and host writes, one spi_ctr access at a time.
module spi2_access_sched
  import rf_ctr_pkg::*;
#(
  parameter int POLL_DIV = POLL_DIV_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        poll_en,
  input  logic        cmd_rd_req,
  input  logic        cmd_wr_req,
  input  logic [31:0] cmd_wr_data,
  output logic        cmd_busy,
  output logic        cmd_done,
  output logic [15:0] cmd_dout,
  output logic        cmd_timeout,
  output logic        poll_vld,
  output logic [15:0] poll_dout,
  output logic [7:0]  overrun_cnt,
  output logic        spi_rd_en,
  output logic        spi_wr_en,
  output logic [31:0] spi_wr_data,
  input  logic [15:0] spi_dout,
  input  logic        spi_dout_vld,
  input  logic        spi_update_vld,
  output state_e      state_dbg
);

  localparam int PW = (POLL_DIV > 0) ? $clog2(POLL_DIV + 1) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_e        state;
  logic [1:0]    gnt;
  logic [TW-1:0] tcnt;
  logic [15:0]   cap;
  logic [PW-1:0] pcnt;
  logic [31:0]   wr_word;
  logic          wr_pend, rd_pend, poll_pend;
  logic          dv_rise, uv_rise, done_edge, tmo_hit;
  logic          grant_wr, grant_rd, grant_poll;
  logic          tick, poll_inflight, tick_drop, poll_to;
  logic [8:0]    ovr_sum;

  sync_edge_det u_dv_sync (.sys_clk(sys_clk), .rst(rst), .d(spi_dout_vld),   .rise(dv_rise));
  sync_edge_det u_uv_sync (.sys_clk(sys_clk), .rst(rst), .d(spi_update_vld), .rise(uv_rise));

  assign grant_wr   = (state == ST_IDLE) && wr_pend;
  assign grant_rd   = (state == ST_IDLE) && !wr_pend && rd_pend;
  assign grant_poll = (state == ST_IDLE) && !wr_pend && !rd_pend && poll_pend;

  assign done_edge     = (gnt == GNT_WR) ? uv_rise : dv_rise;
  assign tmo_hit       = (state == ST_WAIT) && !done_edge && (tcnt == TW'(TIMEOUT - 1));
  assign poll_inflight = (state != ST_IDLE) && (gnt == GNT_POLL);
  assign tick          = poll_en && (pcnt == PW'(POLL_DIV));
  assign tick_drop     = tick && (poll_pend || poll_inflight);
  assign poll_to       = tmo_hit && (gnt == GNT_POLL);

  assign cmd_busy  = wr_pend || rd_pend || ((state != ST_IDLE) && (gnt != GNT_POLL));
  assign state_dbg = state;

  // Command flags only latch while the command side is idle; a simultaneous
  // read and write keeps just the write.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      wr_pend   <= 1'b0;
      rd_pend   <= 1'b0;
      poll_pend <= 1'b0;
      wr_word   <= '0;
      pcnt      <= '0;
    end else begin
      if (grant_wr) begin
        wr_pend <= 1'b0;
      end else if (cmd_wr_req && !cmd_busy) begin
        wr_pend <= 1'b1;
        wr_word <= cmd_wr_data;
      end
      if (grant_rd)
        rd_pend <= 1'b0;
      else if (cmd_rd_req && !cmd_wr_req && !cmd_busy)
        rd_pend <= 1'b1;
      if (grant_poll)
        poll_pend <= 1'b0;
      else if (tick && !poll_inflight)
        poll_pend <= 1'b1;
      if (!poll_en || pcnt == PW'(POLL_DIV))
        pcnt <= '0;
      else
        pcnt <= pcnt + 1'b1;
    end
  end

  // Dropped ticks and abandoned polls can coincide, so add both then clamp.
  always_comb ovr_sum = {1'b0, overrun_cnt} + 9'(tick_drop) + 9'(poll_to);

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) overrun_cnt <= '0;
    else     overrun_cnt <= (ovr_sum > 9'd255) ? 8'd255 : ovr_sum[7:0];
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      gnt         <= GNT_POLL;
      tcnt        <= '0;
      cap         <= '0;
      spi_rd_en   <= 1'b0;
      spi_wr_en   <= 1'b0;
      spi_wr_data <= '0;
      cmd_done    <= 1'b0;
      cmd_dout    <= '0;
      cmd_timeout <= 1'b0;
      poll_vld    <= 1'b0;
      poll_dout   <= '0;
    end else begin
      spi_rd_en   <= 1'b0;
      spi_wr_en   <= 1'b0;
      cmd_done    <= 1'b0;
      cmd_timeout <= 1'b0;
      poll_vld    <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Strobe is registered on the grant so it is high during ISSUE.
          if (grant_wr) begin
            gnt         <= GNT_WR;
            spi_wr_en   <= 1'b1;
            spi_wr_data <= wr_word;
            state       <= ST_ISSUE;
          end else if (grant_rd || grant_poll) begin
            gnt       <= grant_rd ? GNT_RD : GNT_POLL;
            spi_rd_en <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          tcnt  <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (done_edge) begin
            cap   <= (gnt == GNT_WR) ? 16'h0000 : spi_dout;
            state <= ST_DONE;
          end else if (tmo_hit) begin
            cmd_timeout <= (gnt != GNT_POLL);
            state       <= ST_IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (gnt == GNT_POLL) begin
            poll_vld  <= 1'b1;
            poll_dout <= cap;
          end else begin
            cmd_done <= 1'b1;
            cmd_dout <= cap;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi2_access_sched.sv
// Directed bench for spi2_access_sched with a behavioural spi_ctr responder.
module tb_spi2_access_sched;
  import rf_ctr_pkg::*;

  localparam int TMO = 1023;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b1;
  logic        poll_en = 1'b0;
  logic        cmd_rd_req = 1'b0;
  logic        cmd_wr_req = 1'b0;
  logic [31:0] cmd_wr_data = '0;
  logic        cmd_busy, cmd_done, cmd_timeout, poll_vld;
  logic [15:0] cmd_dout, poll_dout;
  logic [7:0]  overrun_cnt;
  logic        spi_rd_en, spi_wr_en;
  logic [31:0] spi_wr_data;
  logic [15:0] spi_dout = '0;
  logic        spi_dout_vld = 1'b0;
  logic        spi_update_vld = 1'b0;
  state_e      state_dbg;

  spi2_access_sched #(.POLL_DIV(20), .TIMEOUT(TMO)) dut (
    .sys_clk(sys_clk), .rst(rst), .poll_en(poll_en),
    .cmd_rd_req(cmd_rd_req), .cmd_wr_req(cmd_wr_req), .cmd_wr_data(cmd_wr_data),
    .cmd_busy(cmd_busy), .cmd_done(cmd_done), .cmd_dout(cmd_dout),
    .cmd_timeout(cmd_timeout), .poll_vld(poll_vld), .poll_dout(poll_dout),
    .overrun_cnt(overrun_cnt), .spi_rd_en(spi_rd_en), .spi_wr_en(spi_wr_en),
    .spi_wr_data(spi_wr_data), .spi_dout(spi_dout), .spi_dout_vld(spi_dout_vld),
    .spi_update_vld(spi_update_vld), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=no_finish exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- spi_ctr responder ----------------
  logic        model_stall = 1'b0;
  logic [15:0] model_data = 16'h0230;
  int rd_left = 0, wr_left = 0;
  bit rd_act = 0, wr_act = 0;

  always @(posedge sys_clk) begin
    #1;
    if (spi_rd_en) begin
      spi_dout_vld = 1'b0;
      rd_act = !model_stall;
      rd_left = 40;
    end else if (rd_act) begin
      rd_left--;
      if (rd_left == 0) begin
        spi_dout = model_data;
        spi_dout_vld = 1'b1;
        rd_act = 0;
      end
    end
    if (spi_wr_en) begin
      spi_update_vld = 1'b0;
      wr_act = !model_stall;
      wr_left = 10;
    end else if (wr_act) begin
      wr_left--;
      if (wr_left == 0) begin
        spi_update_vld = 1'b1;
        wr_act = 0;
      end
    end
  end

  // ---------------- pulse monitor ----------------
  int n_done = 0, n_poll = 0, n_to = 0, n_rd = 0, n_wr = 0, wrap_seen = 0;
  logic [7:0] prev_ovr = '0;

  always @(posedge sys_clk) begin
    #2;
    if (cmd_done)    n_done++;
    if (poll_vld)    n_poll++;
    if (cmd_timeout) n_to++;
    if (spi_rd_en)   n_rd++;
    if (spi_wr_en)   n_wr++;
    if (!rst && overrun_cnt < prev_ovr) wrap_seen++;
    prev_ovr = overrun_cnt;
  end

  // ---------------- scoreboard ----------------
  int total = 0, bad = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic pulse_req(input logic rd, input logic wr, input logic [31:0] d, output int n);
    cmd_rd_req = rd;
    cmd_wr_req = wr;
    cmd_wr_data = d;
    n = cyc;
    step();
    cmd_rd_req = 1'b0;
    cmd_wr_req = 1'b0;
  endtask

  function automatic logic sel(input int which);
    case (which)
      0: return cmd_done;
      1: return poll_vld;
      2: return cmd_timeout;
      3: return spi_wr_en;
      default: return spi_rd_en;
    endcase
  endfunction

  task automatic wait_pulse(input int which, input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      step();
      if (sel(which)) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic check_quiet(input string p);
    chk({p, "_busy"},    32'(cmd_busy),    32'h0);
    chk({p, "_done"},    32'(cmd_done),    32'h0);
    chk({p, "_dout"},    32'(cmd_dout),    32'h0);
    chk({p, "_tmo"},     32'(cmd_timeout), 32'h0);
    chk({p, "_pvld"},    32'(poll_vld),    32'h0);
    chk({p, "_pdout"},   32'(poll_dout),   32'h0);
    chk({p, "_ovr"},     32'(overrun_cnt), 32'h0);
    chk({p, "_rd_en"},   32'(spi_rd_en),   32'h0);
    chk({p, "_wr_en"},   32'(spi_wr_en),   32'h0);
    chk({p, "_wr_data"}, spi_wr_data,      32'h0);
    chk({p, "_state"},   32'(state_dbg),   32'(ST_IDLE));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n, n2, t, s, b_done, b_rd, b_wr, b_poll, b_to, o0, p1, p2, p3;

    // reset
    repeat (3) step();
    check_quiet("rst");
    rst = 1'b0;
    step();
    check_quiet("post_rst");

    // write + read same cycle as a poll tick: write wins, read dropped, poll after
    b_rd = n_rd; b_wr = n_wr; b_done = n_done;
    model_data = 16'h0230;
    poll_en = 1'b1;
    repeat (20) step();
    pulse_req(1'b1, 1'b1, 32'h1234_5678, n);
    poll_en = 1'b0;
    chk("wr_busy", 32'(cmd_busy), 32'h1);
    wait_pulse(3, 10, t);
    chk("wr_strobe_cyc", t - n, 2);
    chk("wr_data", spi_wr_data, 32'h1234_5678);
    chk("wr_no_rd", 32'(spi_rd_en), 32'h0);
    wait_pulse(0, 40, t);
    chk("wr_done_cyc", t - n, 16);
    chk("wr_dout", 32'(cmd_dout), 32'h0);
    chk("wr_busy_drop", 32'(cmd_busy), 32'h0);
    wait_pulse(4, 10, t);
    chk("poll_after_wr_cyc", t - n, 17);
    wait_pulse(1, 80, t);
    chk("poll_after_wr_vld_cyc", t - n, 61);
    chk("poll_after_wr_dout", 32'(poll_dout), 32'h0230);
    repeat (20) step();
    chk("wr_rd_strobes", n_rd - b_rd, 1);
    chk("wr_wr_strobes", n_wr - b_wr, 1);
    chk("wr_done_count", n_done - b_done, 1);

    // read while busy is ignored
    b_rd = n_rd; b_done = n_done;
    model_data = 16'h01D0;
    pulse_req(1'b1, 1'b0, 32'h0, n);
    repeat (8) step();
    chk("rd_busy_mid", 32'(cmd_busy), 32'h1);
    pulse_req(1'b1, 1'b0, 32'h0, n2);
    wait_pulse(0, 100, t);
    chk("rd_done_cyc", t - n, 46);
    exp_q.push_back(32'h01D0);
    chk("rd_dout", 32'(cmd_dout), exp_q.pop_front());
    repeat (80) step();
    chk("rd_done_count", n_done - b_done, 1);
    chk("rd_strobe_count", n_rd - b_rd, 1);

    // responder stalls: command times out
    b_done = n_done;
    model_stall = 1'b1;
    pulse_req(1'b1, 1'b0, 32'h0, n);
    wait_pulse(4, 10, s);
    chk("tmo_strobe_cyc", s - n, 2);
    wait_pulse(2, TMO + 50, t);
    chk("tmo_latency", t - s, TMO + 1);
    chk("tmo_state", 32'(state_dbg), 32'(ST_IDLE));
    chk("tmo_busy", 32'(cmd_busy), 32'h0);
    chk("tmo_no_done", n_done - b_done, 0);
    model_stall = 1'b0;
    repeat (5) step();

    // poll only: ticks at +21 and +42 after a grant land while the poll is in flight
    model_data = 16'h0230;
    o0 = int'(overrun_cnt);
    n = cyc;
    poll_en = 1'b1;
    wait_pulse(1, 200, p1);
    chk("poll1_cyc", p1 - n, 66);
    chk("poll1_dout", 32'(poll_dout), 32'h0230);
    chk("poll1_ovr", int'(overrun_cnt) - o0, 2);
    wait_pulse(1, 200, p2);
    chk("poll2_period", p2 - p1, 63);
    chk("poll2_ovr", int'(overrun_cnt) - o0, 4);
    wait_pulse(1, 200, p3);
    chk("poll3_period", p3 - p2, 63);
    chk("poll3_ovr", int'(overrun_cnt) - o0, 6);
    poll_en = 1'b0;
    repeat (100) step();

    // reset in the middle of WAIT, completion arrives afterwards
    b_done = n_done; b_poll = n_poll; b_rd = n_rd; b_to = n_to;
    model_data = 16'h0555;
    pulse_req(1'b1, 1'b0, 32'h0, n);
    repeat (10) step();
    chk("mid_state_wait", 32'(state_dbg), 32'(ST_WAIT));
    rst = 1'b1;
    step();
    check_quiet("in_rst");
    rst = 1'b0;
    repeat (60) step();
    chk("rstw_no_done", n_done - b_done, 0);
    chk("rstw_no_poll", n_poll - b_poll, 0);
    chk("rstw_no_to", n_to - b_to, 0);
    chk("rstw_rd_count", n_rd - b_rd, 1);
    check_quiet("rstw");
    model_data = 16'h0ABC;
    pulse_req(1'b1, 1'b0, 32'h0, n);
    wait_pulse(0, 100, t);
    chk("rstw_next_cyc", t - n, 46);
    chk("rstw_next_dout", 32'(cmd_dout), 32'h0ABC);

    // poll backlog with stalled responder: overrun saturates
    model_stall = 1'b1;
    poll_en = 1'b1;
    repeat (300 * 21) step();
    chk("ovr_sat", 32'(overrun_cnt), 32'd255);
    chk("ovr_no_wrap", wrap_seen, 0);
    poll_en = 1'b0;
    repeat (10) step();
    chk("ovr_hold", 32'(overrun_cnt), 32'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
